// File: rtl/rcc_rst_seq_pkg.sv
// Shared definitions for the RCC reset sequencer: FSM encoding, default
// parameters and the next-channel picker.
package rcc_rst_seq_pkg;

   localparam int CH_NUM_DEF    = 4;
   localparam int STAGE_NUM_DEF = 2;
   localparam int CNT_W_DEF     = 8;
   localparam int CH_MAX        = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_HOLD    = 2'd1;
   localparam state_t ST_STRETCH = 2'd2;
   localparam state_t ST_RELEASE = 2'd3;

   // One-hot mask of the lowest set bit; zero in, zero out.
   function automatic logic [CH_MAX-1:0] lowest_bit(input logic [CH_MAX-1:0] v);
      return v & (~v + CH_MAX'(1));
   endfunction

endpackage

// File: rtl/rcc_sync_bit.sv
// Single-bit multi-flop synchroniser for an asynchronous level request,
// cleared by the block's synchronous reset.
module rcc_sync_bit
   import rcc_rst_seq_pkg::*;
#(
   parameter int STAGE_NUM = STAGE_NUM_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGE_NUM-1:0] sync_q;

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGE_NUM-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGE_NUM-1];

endmodule

// File: rtl/rcc_rst_seq.sv
// RCC reset sequencer: stretches channel resets and releases them in index
// order. Define RCC_RST_SEQ_FLAG_EN to build the sticky hardware-cause flags.
module rcc_rst_seq
   import rcc_rst_seq_pkg::*;
#(
   parameter int CH_NUM    = CH_NUM_DEF,
   parameter int STAGE_NUM = STAGE_NUM_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [CH_NUM-1:0] rst_req,
   input  logic [CH_NUM-1:0] sw_rst_pulse,
   input  logic [CNT_W-1:0]  stretch_cnt,
   input  logic [CNT_W-1:0]  gap_cnt,
   input  logic              flag_clr,
   output logic [CH_NUM-1:0] ch_rst_n,
   output logic              seq_busy,
   output logic [CH_NUM-1:0] rst_flag
);

   logic [CH_NUM-1:0] req_s;
   logic [CH_NUM-1:0] hit;
   logic [CH_NUM-1:0] rel_mask;
   logic              rel_en;

   state_t            state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [CH_NUM-1:0] pend_q,     pend_d;
   logic [CH_NUM-1:0] ch_rst_n_q;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_sync
      rcc_sync_bit #(
         .STAGE_NUM (STAGE_NUM)
      ) u_sync (
         .clk_i (sys_clk),
         .rst_i (sys_rst),
         .d_i   (rst_req[g]),
         .q_o   (req_s[g])
      );
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      hit      = req_s | sw_rst_pulse;
      rel_mask = CH_NUM'(lowest_bit(CH_MAX'(pend_q)));
      rel_en   = 1'b0;
      state_d  = state_q;
      cnt_d    = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (|hit) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!(|req_s)) begin
               state_d = ST_STRETCH;
               cnt_d   = stretch_cnt;
            end
         end
         ST_STRETCH, ST_RELEASE: begin
            if (cnt_q == '0) begin
               rel_en  = 1'b1;
               cnt_d   = gap_cnt;
               state_d = ((pend_q & ~rel_mask) == '0) ? ST_IDLE : ST_RELEASE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
            // A fresh request abandons the timed phase and restarts the hold.
            if (|hit) state_d = ST_HOLD;
         end
         default: state_d = ST_HOLD;
      endcase

      // Hit is ORed last so it wins over a same-cycle release of that bit.
      pend_d = (pend_q & ~(rel_en ? rel_mask : '0)) | hit;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_HOLD;
         cnt_q      <= '0;
         pend_q     <= '1;
         ch_rst_n_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         ch_rst_n_q <= ~pend_d;
      end
   end

   assign ch_rst_n = ch_rst_n_q;
   assign seq_busy = (state_q != ST_IDLE);

`ifdef RCC_RST_SEQ_FLAG_EN
   logic [CH_NUM-1:0] flag_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         flag_q <= '0;
      end else begin
         flag_q <= (flag_q & ~{CH_NUM{flag_clr}}) | req_s;
      end
   end

   assign rst_flag = flag_q;
`else
   logic unused_flag_clr;

   assign unused_flag_clr = flag_clr;
   assign rst_flag        = '0;
`endif

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Scoreboard bench for rcc_rst_seq: a per-cycle timeline model predicts the
// outputs after every edge and a negedge monitor compares them.
module tb_rcc_rst_seq;

   localparam int CH  = 4;
   localparam int STG = 2;
   localparam int CW  = 8;

`ifdef RCC_RST_SEQ_FLAG_EN
   localparam logic FLAG_EN = 1'b1;
`else
   localparam logic FLAG_EN = 1'b0;
`endif

   typedef enum int {M_OFF, M_HELD, M_TIMING} mode_t;

   typedef struct packed {
      logic [CH-1:0] rst_n;
      logic          busy;
      logic [CH-1:0] flag;
   } exp_t;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic [CH-1:0] rst_req;
   logic [CH-1:0] sw_rst_pulse;
   logic [CW-1:0] stretch_cnt;
   logic [CW-1:0] gap_cnt;
   logic          flag_clr;
   logic [CH-1:0] ch_rst_n;
   logic          seq_busy;
   logic [CH-1:0] rst_flag;

   int n_checks = 0;
   int n_fails  = 0;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model state: pending set, coarse mode and edges left until
   // the next release fires.
   logic [CH-1:0] m_pipe [STG];
   logic [CH-1:0] m_pend;
   logic [CH-1:0] m_flag;
   mode_t         m_mode;
   int            m_left;

   rcc_rst_seq #(
      .CH_NUM    (CH),
      .STAGE_NUM (STG),
      .CNT_W     (CW)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .rst_req      (rst_req),
      .sw_rst_pulse (sw_rst_pulse),
      .stretch_cnt  (stretch_cnt),
      .gap_cnt      (gap_cnt),
      .flag_clr     (flag_clr),
      .ch_rst_n     (ch_rst_n),
      .seq_busy     (seq_busy),
      .rst_flag     (rst_flag)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [CH-1:0] rs;
      logic [CH-1:0] hit;
      exp_t          e;
      if (sys_rst) begin
         for (int s = 0; s < STG; s++) m_pipe[s] = '0;
         m_pend = '1;
         m_flag = '0;
         m_mode = M_HELD;
         m_left = 0;
      end else begin
         rs  = m_pipe[STG-1];
         hit = rs | sw_rst_pulse;
         for (int s = STG - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
         m_pipe[0] = rst_req;
         case (m_mode)
            M_HELD: begin
               if (rs == '0) begin
                  m_mode = M_TIMING;
                  m_left = int'(stretch_cnt) + 1;
               end
            end
            M_TIMING: begin
               m_left--;
               if (m_left == 0) begin
                  for (int i = 0; i < CH; i++) begin
                     if (m_pend[i]) begin
                        m_pend[i] = 1'b0;
                        break;
                     end
                  end
                  m_left = int'(gap_cnt) + 1;
                  if (m_pend == '0) m_mode = M_OFF;
               end
               if (hit != '0) m_mode = M_HELD;
            end
            default: begin
               if (hit != '0) m_mode = M_HELD;
            end
         endcase
         m_pend = m_pend | hit;
         if (FLAG_EN) m_flag = (m_flag & ~{CH{flag_clr}}) | rs;
      end
      e.rst_n = ~m_pend;
      e.busy  = (m_mode != M_OFF);
      e.flag  = m_flag;
      exp_q.push_back(e);
   endtask

   // One clock edge: the model consumes the inputs the DUT sees at that edge.
   task automatic tick();
      @(posedge sys_clk);
      model_step();
      #1;
   endtask

   always @(negedge sys_clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("ch_rst_n", 32'(ch_rst_n), 32'(mon_e.rst_n));
         check("seq_busy", 32'(seq_busy), 32'(mon_e.busy));
         check("rst_flag", 32'(rst_flag), 32'(mon_e.flag));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst      = 1'b1;
      rst_req      = '0;
      sw_rst_pulse = '0;
      stretch_cnt  = 8'd3;
      gap_cnt      = 8'd1;
      flag_clr     = 1'b0;

      // Power-on: releases expected at edges 5, 7, 9, 11 after reset drops.
      repeat (3) tick();
      sys_rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         @(negedge sys_clk);
         for (int i = 0; i < CH; i++)
            check($sformatf("poweron_bit%0d_edge%0d", i, k), 32'(ch_rst_n[i]), 32'(k >= 5 + 2 * i));
         check($sformatf("poweron_busy_edge%0d", k), 32'(seq_busy), 32'(k < 11));
      end
      repeat (5) tick();

      // Hardware request on channel 2.
      stretch_cnt = 8'd5;
      rst_req     = 4'b0100;
      tick();
      tick();
      @(negedge sys_clk);
      check("hwreq_before_sync", 32'(ch_rst_n), 32'hf);
      tick();
      @(negedge sys_clk);
      check("hwreq_asserted", 32'(ch_rst_n), 32'hb);
      repeat (7) tick();
      rst_req = '0;
      repeat (25) tick();

      // Software pulse on channels 1 and 3.
      gap_cnt      = 8'd2;
      sw_rst_pulse = 4'b1010;
      tick();
      sw_rst_pulse = '0;
      @(negedge sys_clk);
      check("swpulse_asserted", 32'(ch_rst_n), 32'h5);
      repeat (30) tick();

      // Re-trigger channel 0 just after it has been released.
      stretch_cnt  = 8'd2;
      gap_cnt      = 8'd3;
      sw_rst_pulse = 4'b1111;
      tick();
      sw_rst_pulse = '0;
      repeat (5) tick();
      @(negedge sys_clk);
      check("retrig_bit0_released", 32'(ch_rst_n), 32'h1);
      sw_rst_pulse = 4'b0001;
      tick();
      sw_rst_pulse = '0;
      @(negedge sys_clk);
      check("retrig_bit0_reasserted", 32'(ch_rst_n), 32'h0);
      repeat (40) tick();

      // Flag set and clear in the same cycle: set wins.
      rst_req = 4'b0010;
      repeat (4) tick();
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      tick();
      @(negedge sys_clk);
      check("flag_set_wins", 32'(rst_flag), FLAG_EN ? 32'h2 : 32'h0);
      rst_req = '0;
      repeat (5) tick();
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      tick();
      @(negedge sys_clk);
      check("flag_cleared", 32'(rst_flag), 32'h0);
      repeat (30) tick();

      // Reset in the middle of a stretch.
      stretch_cnt  = 8'd6;
      sw_rst_pulse = 4'b1111;
      tick();
      sw_rst_pulse = '0;
      repeat (3) tick();
      sys_rst = 1'b1;
      tick();
      @(negedge sys_clk);
      check("midrst_ch_rst_n", 32'(ch_rst_n), 32'h0);
      check("midrst_busy", 32'(seq_busy), 32'h1);
      check("midrst_flag", 32'(rst_flag), 32'h0);
      sys_rst = 1'b0;
      repeat (25) tick();

      // Randomised traffic.
      for (int c = 0; c < 1500; c++) begin
         tick();
         if ($urandom_range(0, 19) == 0) begin
            int idx = $urandom_range(0, CH - 1);
            rst_req[idx] = 1'b1;
         end
         if ($urandom_range(0, 5) == 0) rst_req = rst_req & 4'($urandom);
         sw_rst_pulse = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
         flag_clr     = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) stretch_cnt = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 49) == 0) gap_cnt = 8'($urandom_range(0, 3));
         sys_rst = ($urandom_range(0, 399) == 0);
      end
      sys_rst      = 1'b0;
      rst_req      = '0;
      sw_rst_pulse = '0;
      flag_clr     = 1'b0;
      repeat (60) tick();

      @(negedge sys_clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
